// File: rtl/uart_image_transfer.sv
`default_nettype none
// ============================================================================
// Module   : uart_image_transfer
// Purpose  : Moves a picture between UART byte ports and word-addressed memory
//            (4 bytes per 32-bit word, little-endian).
// Revision : 1.0
// ============================================================================
module uart_image_transfer #(
  parameter int P_NUM_WORDS = 25344,
  parameter int P_ADDR_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_rx,
  input  logic                start_tx,
  output logic                busy,
  output logic                done,
  input  logic [7:0]          rx_byte,
  input  logic                rx_byte_stb,
  output logic [7:0]          tx_byte,
  output logic                tx_byte_stb,
  input  logic                tx_byte_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [P_ADDR_W-1:0] mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RX_COLLECT = 3'd1,
    S_TX_READ    = 3'd2,
    S_TX_WAIT    = 3'd3,
    S_TX_SEND    = 3'd4,
    S_TX_GAP     = 3'd5,
    S_FINISH     = 3'd6
  } state_t;

  localparam logic [P_ADDR_W-1:0] c_last_word = P_ADDR_W'(P_NUM_WORDS - 1);

  state_t              r_state;
  logic [P_ADDR_W-1:0] r_word_idx;
  logic [1:0]          r_lane;
  logic [31:0]         r_word;
  logic                r_last_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_word_idx  <= '0;
      r_lane      <= '0;
      r_word      <= '0;
      r_last_wr   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_byte     <= '0;
      tx_byte_stb <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_word_idx <= '0;
          r_lane     <= '0;
          r_last_wr  <= 1'b0;
          if (start_rx) begin
            busy    <= 1'b1;
            r_state <= S_RX_COLLECT;
          end else if (start_tx) begin
            busy     <= 1'b1;
            mem_en   <= 1'b1;
            mem_addr <= '0;
            r_state  <= S_TX_READ;
          end
        end

        S_RX_COLLECT: begin
          // The final write is on the bus this cycle; no further bytes belong to the picture.
          if (mem_en && r_last_wr) begin
            done    <= 1'b1;
            r_state <= S_FINISH;
          end else if (rx_byte_stb) begin
            r_word[{r_lane, 3'b000} +: 8] <= rx_byte;
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
              mem_en     <= 1'b1;
              mem_we     <= 1'b1;
              mem_addr   <= r_word_idx;
              mem_wdata  <= {rx_byte, r_word[23:0]};
              r_word_idx <= r_word_idx + P_ADDR_W'(1);
              r_last_wr  <= (r_word_idx == c_last_word);
            end
          end
        end

        S_TX_READ: r_state <= S_TX_WAIT;

        S_TX_WAIT: begin
          r_word      <= mem_rdata;
          r_lane      <= '0;
          tx_byte     <= mem_rdata[7:0];
          tx_byte_stb <= 1'b1;
          r_state     <= S_TX_SEND;
        end

        S_TX_SEND: begin
          if (tx_byte_ack) begin
            tx_byte_stb <= 1'b0;
            if (r_lane != 2'd3) begin
              r_lane  <= r_lane + 2'd1;
              r_state <= S_TX_GAP;
            end else if (r_word_idx == c_last_word) begin
              done    <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_word_idx <= r_word_idx + P_ADDR_W'(1);
              mem_en     <= 1'b1;
              mem_addr   <= r_word_idx + P_ADDR_W'(1);
              r_state    <= S_TX_READ;
            end
          end
        end

        S_TX_GAP: begin
          tx_byte     <= r_word[{r_lane, 3'b000} +: 8];
          tx_byte_stb <= 1'b1;
          r_state     <= S_TX_SEND;
        end

        S_FINISH: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_image_transfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_image_transfer
// Purpose  : Scoreboard bench for uart_image_transfer (4-word and 1-word builds).
// Revision : 1.0
// ============================================================================
module tb_uart_image_transfer;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-word instance
  logic        start_rx, start_tx, busy, done;
  logic [7:0]  rx_byte, tx_byte;
  logic        rx_byte_stb, tx_byte_stb, tx_byte_ack;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  // 1-word instance
  logic        b_start_rx, b_start_tx, b_busy, b_done;
  logic [7:0]  b_rx_byte, b_tx_byte;
  logic        b_rx_byte_stb, b_tx_byte_stb, b_tx_byte_ack;
  logic        b_mem_en, b_mem_we;
  logic [15:0] b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  uart_image_transfer #(.P_NUM_WORDS(4), .P_ADDR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_rx(start_rx), .start_tx(start_tx),
    .busy(busy), .done(done), .rx_byte(rx_byte), .rx_byte_stb(rx_byte_stb),
    .tx_byte(tx_byte), .tx_byte_stb(tx_byte_stb), .tx_byte_ack(tx_byte_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  uart_image_transfer #(.P_NUM_WORDS(1), .P_ADDR_W(16)) u_dut_one (
    .clk(clk), .rst_n(rst_n), .start_rx(b_start_rx), .start_tx(b_start_tx),
    .busy(b_busy), .done(b_done), .rx_byte(b_rx_byte), .rx_byte_stb(b_rx_byte_stb),
    .tx_byte(b_tx_byte), .tx_byte_stb(b_tx_byte_stb), .tx_byte_ack(b_tx_byte_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory models: registered read data, one cycle after the access.
  logic [31:0] mem_a [4];
  logic [31:0] b_word = 32'h8765_4321;
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= mem_a[mem_addr[1:0]];
  always @(posedge clk) if (b_mem_en && !b_mem_we) b_mem_rdata <= b_word;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wr_q[$];
  logic [7:0]  tx_q[$];

  int done_cnt = 0, en_cnt = 0, rd_cnt = 0, b_done_cnt = 0, b_en_cnt = 0;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && !mem_we) rd_cnt <= rd_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
    if (b_mem_en) b_en_cnt <= b_en_cnt + 1;
  end

  always @(negedge clk) begin : wr_monitor
    wr_t e;
    if (rst_n && mem_en && mem_we) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 64'd1, 64'd0);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_tx_byte"}, 64'(tx_byte), 64'd0);
    chk({tag, "_tx_stb"}, 64'(tx_byte_stb), 64'd0);
    chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Bytes base+first .. base+first+n-1; byte i lands in word i/4, lane i%4.
  task automatic rx_stream(input int first, input int n, input logic [7:0] base);
    wr_t e;
    for (int i = first; i < first + n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      rx_byte     = base + 8'(i);
      rx_byte_stb = 1'b1;
      if (i % 4 == 3) begin
        e.addr = 16'(i / 4);
        e.data = {base + 8'(i), base + 8'(i - 1), base + 8'(i - 2), base + 8'(i - 3)};
        e.cyc  = cyc + 1;
        wr_q.push_back(e);
      end
      step();
      rx_byte_stb = 1'b0;
    end
  endtask

  task automatic rx_complete(input int done_before);
    step();
    chk("rx_done", 64'(done), 64'd1);
    chk("rx_busy_at_done", 64'(busy), 64'd1);
    step();
    chk("rx_done_pulse", 64'(done), 64'd0);
    chk("rx_busy_low", 64'(busy), 64'd0);
    chk("rx_done_once", 64'(done_cnt - done_before), 64'd1);
    chk("rx_all_writes", 64'(wr_q.size()), 64'd0);
  endtask

  task automatic tx_run(input int nbytes, output int last_ack);
    int s, rise, prev_ack, w, dly;
    logic [7:0] held, exp;
    bit unstable;
    last_ack    = 0;
    start_tx    = 1'b1;
    s           = cyc;
    step();
    start_tx    = 1'b0;
    chk("tx_busy", 64'(busy), 64'd1);
    chk("tx_first_read", 64'(mem_en && !mem_we), 64'd1);
    chk("tx_first_addr", 64'(mem_addr), 64'd0);
    prev_ack = s;
    for (int i = 0; i < nbytes; i++) begin
      w = 0;
      while (!tx_byte_stb && w < 20) begin
        step();
        w++;
      end
      if (!tx_byte_stb) begin
        chk("tx_stb_timeout", 64'd0, 64'd1);
        return;
      end
      rise = cyc;
      if (i == 0) chk("tx_first_stb", 64'(rise - s), 64'd3);
      else        chk("tx_gap", 64'(rise - prev_ack - 1), (i % 4 == 0) ? 64'd2 : 64'd1);
      exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
      chk("tx_byte", 64'(tx_byte), 64'(exp));
      held     = tx_byte;
      unstable = 1'b0;
      dly = (i == 0) ? 0 : (i == 1) ? 50 : int'($urandom_range(0, 50));
      repeat (dly) begin
        step();
        if (!tx_byte_stb || tx_byte !== held) unstable = 1'b1;
      end
      chk("tx_stable", 64'(unstable), 64'd0);
      tx_byte_ack = 1'b1;
      prev_ack    = cyc;
      step();
      tx_byte_ack = 1'b0;
      chk("tx_stb_drop", 64'(tx_byte_stb), 64'd0);
    end
    last_ack = prev_ack;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, e0, a;
    rst_n = 1'b0;
    {start_rx, start_tx, rx_byte, rx_byte_stb, tx_byte_ack} = '0;
    {b_start_rx, b_start_tx, b_rx_byte, b_rx_byte_stb, b_tx_byte_ack} = '0;
    mem_a[0] = 32'hDDCC_BBAA;
    mem_a[1] = 32'h4433_2211;
    mem_a[2] = 32'h8899_7766;
    mem_a[3] = 32'hF0E0_D0C0;
    repeat (3) step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Strobe in IDLE must not start anything.
    e0 = en_cnt;
    rx_byte = 8'hA5; rx_byte_stb = 1'b1;
    step();
    rx_byte_stb = 1'b0;
    repeat (3) step();
    chk("idle_stb_no_mem", 64'(en_cnt - e0), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Load a 4-word picture, bytes 0x00..0x0F.
    d0 = done_cnt; r0 = rd_cnt;
    start_rx = 1'b1;
    step();
    start_rx = 1'b0;
    chk("rx_busy", 64'(busy), 64'd1);
    rx_stream(0, 16, 8'h00);
    rx_complete(d0);
    chk("rx_no_reads", 64'(rd_cnt - r0), 64'd0);

    // Send the 4-word picture.
    for (int wi = 0; wi < 4; wi++)
      for (int l = 0; l < 4; l++) tx_q.push_back(mem_a[wi][8*l +: 8]);
    d0 = done_cnt; r0 = rd_cnt;
    tx_run(16, a);
    chk("tx_done", 64'(done), 64'd1);
    chk("tx_done_cycle", 64'(cyc - a), 64'd1);
    step();
    chk("tx_busy_low", 64'(busy), 64'd0);
    chk("tx_done_once", 64'(done_cnt - d0), 64'd1);
    chk("tx_reads", 64'(rd_cnt - r0), 64'd4);
    chk("tx_all_bytes", 64'(tx_q.size()), 64'd0);

    // Simultaneous starts go to RX; stray start_tx/ack mid-RX is ignored.
    d0 = done_cnt; r0 = rd_cnt;
    start_rx = 1'b1; start_tx = 1'b1;
    step();
    start_rx = 1'b0; start_tx = 1'b0;
    chk("arb_busy", 64'(busy), 64'd1);
    chk("arb_no_read", 64'(mem_en), 64'd0);
    rx_stream(0, 6, 8'h20);
    start_tx = 1'b1; tx_byte_ack = 1'b1;
    step();
    start_tx = 1'b0; tx_byte_ack = 1'b0;
    rx_stream(6, 10, 8'h20);
    rx_complete(d0);
    chk("arb_no_reads", 64'(rd_cnt - r0), 64'd0);
    chk("arb_no_tx_stb", 64'(tx_byte_stb), 64'd0);

    // Asynchronous reset mid-RX, between clock edges.
    start_rx = 1'b1;
    step();
    start_rx = 1'b0;
    rx_stream(0, 6, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    d0 = done_cnt;
    start_rx = 1'b1;
    step();
    start_rx = 1'b0;
    rx_stream(0, 16, 8'h00);
    rx_complete(d0);

    // One-word picture: RX.
    d0 = b_done_cnt; e0 = b_en_cnt;
    b_start_rx = 1'b1;
    step();
    b_start_rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      b_rx_byte = 8'h40 + 8'(i);
      b_rx_byte_stb = 1'b1;
      step();
      b_rx_byte_stb = 1'b0;
    end
    chk("one_rx_write", 64'(b_mem_en && b_mem_we), 64'd1);
    chk("one_rx_addr", 64'(b_mem_addr), 64'd0);
    chk("one_rx_data", 64'(b_mem_wdata), 64'h4342_4140);
    step();
    chk("one_rx_done", 64'(b_done), 64'd1);
    step();
    chk("one_rx_busy_low", 64'(b_busy), 64'd0);
    chk("one_rx_done_once", 64'(b_done_cnt - d0), 64'd1);
    chk("one_rx_single_access", 64'(b_en_cnt - e0), 64'd1);

    // One-word picture: TX.
    d0 = b_done_cnt;
    b_start_tx = 1'b1;
    step();
    b_start_tx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 20 && !b_tx_byte_stb; w++) step();
      chk("one_tx_stb", 64'(b_tx_byte_stb), 64'd1);
      chk("one_tx_byte", 64'(b_tx_byte), 64'(b_word[8*i +: 8]));
      b_tx_byte_ack = 1'b1;
      step();
      b_tx_byte_ack = 1'b0;
    end
    chk("one_tx_done", 64'(b_done), 64'd1);
    step();
    chk("one_tx_busy_low", 64'(b_busy), 64'd0);
    chk("one_tx_done_once", 64'(b_done_cnt - d0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
